// File: rtl/dmem_responder.sv
// Off-chip data memory model answering line read/write requests after a fixed latency.
// Optional DMEM_RANGE_CHECK_EN adds err_o and suppresses out-of-range accesses instead of wrapping.
module dmem_responder #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] wdata_i,
    output logic         ack_o,
    output logic [255:0] rdata_o,
    output logic         busy_o
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic         err_o
`endif
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [255:0]    wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            ack_d, busy_d;
    logic [255:0]    rdata_d;
    logic            oor_c;
    logic            unused_addr;

    logic [255:0]    mem [DEPTH];

`ifdef DMEM_RANGE_CHECK_EN
    assign oor_c = 32'(addr_i[31:5]) >= 32'(DEPTH);
`else
    assign oor_c = 1'b0;
`endif
    // Byte-offset bits (and upper bits when wrapping) carry no meaning for a line access.
    assign unused_addr = ^addr_i;

    // Next-state, transaction latch and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    wr_d    = write_i;
                    idx_d   = addr_i[5 +: IW];
                    wdata_d = wdata_i;
                    err_d   = oor_c;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        // The read is taken on the edge entering ACK so rdata_o is registered.
        if (state_d == ST_ACK) begin
            ack_d = 1'b1;
            if (!wr_d && !err_d) begin
                rdata_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            ack_o   <= 1'b0;
            busy_o  <= 1'b0;
            rdata_o <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            err_o   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            ack_o   <= ack_d;
            busy_o  <= busy_d;
            rdata_o <= rdata_d;
`ifdef DMEM_RANGE_CHECK_EN
            err_o   <= ack_d && err_d;
`endif
        end
    end

    // Writes commit at the end of the ACK cycle; a reset in that cycle aborts them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == ST_ACK) && wr_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Off-chip data memory model: the responder end of the line-based memory request/acknowledge interface driven by the data-cache controller in the MEM stage.
- Accepts one 256-bit line read or write per request.
- Returns ack after a fixed programmable latency, stalling the pipeline for the miss duration.
- Storage is an internal line array; MEM/WB downstream receives data only via the cache.

Parameters:
DEPTH, 512, number of 256-bit lines stored; power of two, >=2
LATENCY, 10, cycles from request acceptance to ack_o; integer >=1

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
req_i  input  1  request valid, held high by initiator until ack_o
write_i  input  1  1 = line write, 0 = line read; held stable with req_i
addr_i  input  32  byte address; bits [4:0] ignored, line index = addr_i[5+log2(DEPTH)-1:5]
wdata_i  input  256  write line data; held stable with req_i
ack_o  output  1  one-cycle completion pulse
rdata_o  output  256  read line data, valid only while ack_o=1 on a read
busy_o  output  1  high from acceptance until the ack cycle, inclusive

Behaviour:
- Reset is synchronous, active-high; one clock; no other clock domain.
- Reset values: ack_o=0, rdata_o=0, busy_o=0, state=IDLE, latency counter=0. Array contents are not cleared by reset.
- State machine: IDLE, WAIT, ACK.
- IDLE:
  - req_i=1 at a rising edge latches write_i, line index and wdata_i into internal registers and sets busy_o=1.
  - Counter loads LATENCY-1.
  - Next state is WAIT, or ACK directly if LATENCY=1.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, next state is ACK.
  - req_i, addr_i, write_i and wdata_i changes are ignored; only latched values are used.
- ACK (exactly one cycle):
  - ack_o=1.
  - Read: rdata_o = array[latched index].
  - Write: array[latched index] <= latched wdata at the end of this cycle; rdata_o=0.
  - Next state IDLE; ack_o and busy_o return to 0.
- Latency: ack_o rises exactly LATENCY cycles after the acceptance edge.
- Back-to-back requests:
  - If req_i is still high in the cycle after ACK, it is treated as a new request, accepted in IDLE.
  - Minimum request spacing is LATENCY+1 cycles.
  - Initiator drops req_i on the edge where it samples ack_o=1.
- Read after write to the same line returns the new data, since the write commits in the ACK cycle.
- Reset mid-operation (WAIT or ACK): the transaction is aborted, no array write occurs, and ack_o=0 on the next cycle. A request held across reset is re-accepted after rst_i falls.
- Address width: index bits above log2(DEPTH) are ignored (modulo wrap) unless DMEM_RANGE_CHECK_EN is defined.
- rdata_o is registered; no combinational path from any input to any output.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - At acceptance, if addr_i[31:5] >= DEPTH, the out-of-range condition is latched.
  - In ACK, err_o=1 with ack_o, rdata_o=0, and the write is suppressed.
  - err_o is 0 otherwise.
- Undefined: no err_o port; out-of-range addresses wrap modulo DEPTH lines.

Test Plan:
1. Reset then write: rst_i=1 for 2 cycles, write_i=1, addr_i=0x0000_0040, wdata_i={8{32'hDEADBEEF}} -> busy_o=1 from next cycle, ack_o pulses exactly 10 cycles after acceptance, rdata_o=0.
2. Read back: read addr_i=0x0000_005F, same line as test 1 -> ack_o after 10 cycles, rdata_o={8{32'hDEADBEEF}} during the ack cycle only.
3. Back-to-back: write line 3 = 256'h1, req_i held into the next read of line 3 -> second ack 11 cycles after the first, rdata_o=256'h1.
4. Mid-operation reset: accept write line 7 = all-ones, assert rst_i at cycle 5 -> no ack_o, busy_o=0; later read of line 7 returns its prior value.
5. LATENCY=1 instance: read request -> ack_o on the first cycle after acceptance, busy_o high 1 cycle, back-to-back spacing 2 cycles.
6. Out of range: addr_i=0x0000_4000 with DEPTH=512 (line 512):
   - With DMEM_RANGE_CHECK_EN: err_o=1 with ack_o, and line 0 is unchanged by a write.
   - Without: the write aliases to line 0, and a read of line 0 returns the written data.
